// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state and owner encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_F = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (fetch F, load/store D) and memory-side signals for mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_done;
  logic [DATA_WIDTH-1:0] f_rdata;

  logic                  d_req;
  logic                  d_wen;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [BE_WIDTH-1:0]   d_be;
  logic                  d_done;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  err;

  // Handshake: a requester holds req (and stable fields) until it samples its done
  // pulse; mem_req is held with stable mem_* fields until mem_ready is sampled high.
  logic                  mem_req;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_wen, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output f_done, f_rdata, d_done, d_rdata, err,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output f_req, f_addr, d_req, d_wen, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  f_done, f_rdata, d_done, d_rdata, err,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_port_arbiter_arb_grant_select.sv
// Winner selection (D over F) with a saturating consecutive-D counter that forces F through.
module arb_grant_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   f_req,
  input  logic   d_req,
  input  logic   grant,
  output owner_e winner
);

  localparam int CW = cnt_width(MAX_CONSEC);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CONSEC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    winner = OWNER_F;
    if (d_req && !(f_req && (cnt_q == CNT_MAX))) winner = OWNER_D;

    cnt_d = cnt_q;
    // Only D grants that actually made F wait count toward the streak.
    if (grant) begin
      if ((winner == OWNER_D) && f_req) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else                              cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (F) and load/store (D), one access at a time.
// Optional ISSUE timeout with err reporting is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_CONSEC     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output state_e              state_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  if (MAX_CONSEC < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MAX_CONSEC and TIMEOUT_CYCLES must be >= 1");
  end

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                winner;
  logic                  grant;
  logic                  mem_req_q, mem_req_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  f_done_q, f_done_d;
  logic                  d_done_q, d_done_d;
  logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  arb_grant_select #(.MAX_CONSEC(MAX_CONSEC)) u_grant (
    .clk    (clk),
    .reset  (reset),
    .f_req  (bus.f_req),
    .d_req  (bus.d_req),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    mem_req_d = mem_req_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    f_done_d  = 1'b0;
    d_done_d  = 1'b0;
    grant     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    err_d     = 1'b0;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.f_req || bus.d_req) begin
          grant     = 1'b1;
          owner_d   = winner;
          mem_req_d = 1'b1;
          state_d   = ST_ISSUE;
`ifdef MEM_TIMEOUT_EN
          tmo_d     = '0;
`endif
          // Loads and fetches always read the full word.
          if (winner == OWNER_D) begin
            wen_d   = bus.d_wen;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            be_d    = bus.d_wen ? bus.d_be : '1;
          end else begin
            wen_d   = 1'b0;
            addr_d  = bus.f_addr;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          if (owner_q == OWNER_F) begin
            f_done_d  = 1'b1;
            f_rdata_d = bus.mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!wen_q) d_rdata_d = bus.mem_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          err_d     = 1'b1;
          if (owner_q == OWNER_F) begin
            f_done_d  = 1'b1;
            f_rdata_d = '0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_F;
      mem_req_q <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      f_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mem_req_q <= mem_req_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      f_done_q  <= f_done_d;
      d_done_q  <= d_done_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign state_o       = state_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.f_done    = f_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
`ifdef MEM_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, arbitration order, wait states, reset, timeout.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic   clk = 1'b0;
  logic   reset;
  state_e state_o;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Scoreboard: expected owner of each done pulse (1 = D, 0 = F), in order.
  logic [0:0] exp_q[$];
  logic       exp_err  = 1'b0;
  int         done_cnt = 0;

  int          f_left    = 0;
  int          d_left    = 0;
  logic        mem_hang  = 1'b0;
  int          mem_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] mem_data  = '0;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .MAX_CONSEC     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_all(input string tag, input int budget);
    int n = 0;
    while ((f_left != 0 || d_left != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(f_left == 0 && d_left == 0), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: raises mem_ready after mem_delay ISSUE cycles unless hung.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !mem_hang) begin
        if (wait_cnt >= mem_delay) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_data;
        end else begin
          bus.mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ready = 1'b0;
        wait_cnt      = 0;
      end
    end
  end

  // Requesters: keep req high across done while accesses remain, drop on the last one.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.f_done && f_left > 0) begin
        f_left--;
        if (f_left == 0) bus.f_req = 1'b0;
      end
      if (bus.d_done && d_left > 0) begin
        d_left--;
        if (d_left == 0) bus.d_req = 1'b0;
      end
    end
  end

  // Done monitor: exclusivity, grant order against the scoreboard, err flag.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.f_done || bus.d_done) begin
        done_cnt++;
        chk("done_exclusive", 64'(bus.f_done & bus.d_done), 64'd0);
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("grant_order", 64'(bus.d_done), 64'(exp_q.pop_front()));
        chk("done_err", 64'(bus.err), 64'(exp_err));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int base;
    reset       = 1'b1;
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wen   = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
    repeat (3) @(negedge clk);

    chk("rst_state",   64'(state_o),     64'(ST_IDLE));
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_f_done",  64'(bus.f_done),  64'd0);
    chk("rst_d_done",  64'(bus.d_done),  64'd0);
    chk("rst_f_rdata", 64'(bus.f_rdata), 64'd0);
    chk("rst_d_rdata", 64'(bus.d_rdata), 64'd0);
    chk("rst_err",     64'(bus.err),     64'd0);
    chk("rst_mem_be",  64'(bus.mem_be),  64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch only, immediate ready: IDLE, ISSUE, DONE.
    exp_q.push_back(1'b0);
    mem_data   = 32'hDEAD_BEEF;
    mem_delay  = 0;
    bus.f_addr = 32'h100;
    f_left     = 1;
    bus.f_req  = 1'b1;
    @(negedge clk);
    chk("t1_state_issue", 64'(state_o),      64'(ST_ISSUE));
    chk("t1_mem_req",     64'(bus.mem_req),  64'd1);
    chk("t1_mem_addr",    64'(bus.mem_addr), 64'h100);
    chk("t1_mem_be",      64'(bus.mem_be),   64'hF);
    chk("t1_mem_wen",     64'(bus.mem_wen),  64'd0);
    @(negedge clk);
    chk("t1_f_done",  64'(bus.f_done),  64'd1);
    chk("t1_d_done",  64'(bus.d_done),  64'd0);
    chk("t1_f_rdata", 64'(bus.f_rdata), 64'hDEAD_BEEF);
    wait_all("t1_complete", 20);

    // Simultaneous: D store wins first, then F.
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    mem_data    = 32'hA5A5_A5A5;
    bus.d_wen   = 1'b1;
    bus.d_addr  = 32'h2000;
    bus.d_wdata = 32'h55;
    bus.d_be    = 4'h3;
    bus.f_addr  = 32'h104;
    d_left      = 1;
    f_left      = 1;
    bus.d_req   = 1'b1;
    bus.f_req   = 1'b1;
    @(negedge clk);
    chk("t2_mem_req",   64'(bus.mem_req),   64'd1);
    chk("t2_mem_wen",   64'(bus.mem_wen),   64'd1);
    chk("t2_mem_addr",  64'(bus.mem_addr),  64'h2000);
    chk("t2_mem_wdata", 64'(bus.mem_wdata), 64'h55);
    chk("t2_mem_be",    64'(bus.mem_be),    64'h3);
    wait_all("t2_complete", 40);
    chk("t2_store_keeps_d_rdata", 64'(bus.d_rdata), 64'd0);
    chk("t2_f_rdata",             64'(bus.f_rdata), 64'hA5A5_A5A5);

    // Starvation guard: D,D,D,D,F,D,D with MAX_CONSEC = 4.
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    mem_data   = 32'h0BAD_F00D;
    bus.d_wen  = 1'b0;
    bus.d_addr = 32'h3000;
    bus.f_addr = 32'h108;
    d_left     = 6;
    f_left     = 1;
    bus.d_req  = 1'b1;
    bus.f_req  = 1'b1;
    wait_all("t3_complete", 200);
    chk("t3_order_drained", 64'(exp_q.size()), 64'd0);
    chk("t3_d_rdata",       64'(bus.d_rdata),  64'h0BAD_F00D);
    chk("t3_f_rdata",       64'(bus.f_rdata),  64'h0BAD_F00D);

    // Wait states: ready after 5 extra cycles, six stable ISSUE cycles, one done.
    exp_q.push_back(1'b1);
    mem_delay  = 5;
    mem_data   = 32'h1234_5678;
    bus.d_addr = 32'h40;
    base       = done_cnt;
    d_left     = 1;
    bus.d_req  = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus.mem_req && n < 20) begin
      chk("t4_addr_stable", 64'(bus.mem_addr), 64'h40);
      n++;
      @(negedge clk);
    end
    chk("t4_issue_cycles", 64'(n), 64'd6);
    wait_all("t4_complete", 20);
    chk("t4_done_once", 64'(done_cnt - base), 64'd1);
    chk("t4_d_rdata",   64'(bus.d_rdata),     64'h1234_5678);
    mem_delay = 0;

    // Reset in the middle of ISSUE: mem_req drops at once, no done.
    mem_hang   = 1'b1;
    bus.f_addr = 32'h300;
    base       = done_cnt;
    f_left     = 1;
    bus.f_req  = 1'b1;
    @(negedge clk);
    chk("t5_mem_req_before", 64'(bus.mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_mem_req_async", 64'(bus.mem_req), 64'd0);
    chk("t5_state_idle",    64'(state_o),     64'(ST_IDLE));
    chk("t5_f_rdata_clr",   64'(bus.f_rdata), 64'd0);
    bus.f_req = 1'b0;
    f_left    = 0;
    @(negedge clk);
    reset    = 1'b0;
    mem_hang = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done",      64'(done_cnt - base), 64'd0);
    chk("t5_mem_req_idle", 64'(bus.mem_req),     64'd0);
    exp_q.push_back(1'b0);
    mem_data   = 32'hCAFE_F00D;
    bus.f_addr = 32'h400;
    f_left     = 1;
    bus.f_req  = 1'b1;
    wait_all("t5_post_reset_fetch", 20);
    chk("t5_f_rdata",  64'(bus.f_rdata),  64'hCAFE_F00D);
    chk("t5_mem_addr", 64'(bus.mem_addr), 64'h400);

`ifdef MEM_TIMEOUT_EN
    // Timeout: memory never answers, abort after TMO ISSUE cycles with err.
    exp_q.push_back(1'b1);
    exp_err    = 1'b1;
    mem_hang   = 1'b1;
    bus.d_wen  = 1'b0;
    bus.d_addr = 32'h500;
    d_left     = 1;
    bus.d_req  = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t6_issue_cycles", 64'(n),           64'(TMO));
    chk("t6_d_done",       64'(bus.d_done),  64'd1);
    chk("t6_err",          64'(bus.err),     64'd1);
    chk("t6_d_rdata_zero", 64'(bus.d_rdata), 64'd0);
    wait_all("t6_complete", 20);
    exp_err  = 1'b0;
    mem_hang = 1'b0;
`else
    chk("t6_err_tied_low", 64'(bus.err), 64'd0);
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
